// File: rtl/addr_reg_bank_pkg.sv
// Shared constants for the address register bank: bus width and the
// default move-bus codes of the address register channels.
package addr_reg_bank_pkg;

    localparam int unsigned DATA_WIDTH = 8;

    localparam logic [3:0] AR0 = 4'h8;
    localparam logic [3:0] AR1 = 4'h9;
    localparam logic [3:0] AR2 = 4'hA;
    localparam logic [3:0] AR3 = 4'hB;

    function automatic logic [3:0] chan_code(input logic [3:0] base, input int unsigned ch);
        return base + 4'(ch);
    endfunction

    // Byte counters need at least one bit even when a channel is a single byte.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addr_reg_chan.sv
// One address register channel: MS-first byte staging with atomic commit,
// snapshot-coherent MS-first readback and post-increment.
module addr_reg_chan
    import addr_reg_bank_pkg::*;
#(
    parameter int unsigned        DATA_W     = DATA_WIDTH,
    parameter int unsigned        ADDR_W     = 16,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              ld_busy,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned NBYTES = ADDR_W / DATA_W;
    localparam int unsigned IDX_W  = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stage_q, stage_d;
    logic [ADDR_W-1:0] snap_q, snap_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic              commit;
    logic [ADDR_W-1:0] rd_src;
    logic [DATA_W-1:0] rd_byte;

    // Write side: the committed value is the staged bytes with this byte as LS.
    always_comb begin
        stage_d  = stage_q;
        wr_idx_d = wr_idx_q;
        commit   = 1'b0;
        if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_idx_q == IDX_W'(b)) begin
                    stage_d[(NBYTES-1-b)*DATA_W +: DATA_W] = wr_data;
                end
            end
            if (wr_idx_q == LAST_IDX) begin
                commit   = 1'b1;
                wr_idx_d = '0;
            end else begin
                wr_idx_d = wr_idx_q + IDX_W'(1);
            end
        end
    end

    // Commit beats increment.
    always_comb begin
        addr_d = addr_q;
        if (commit) begin
            addr_d = stage_d;
        end else if (inc) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    // Read side: first byte from the live value, the rest from the snapshot.
    always_comb begin
        rd_src  = (rd_idx_q == '0) ? addr_q : snap_q;
        rd_byte = '0;
        for (int b = 0; b < NBYTES; b++) begin
            if (rd_idx_q == IDX_W'(b)) begin
                rd_byte = rd_src[(NBYTES-1-b)*DATA_W +: DATA_W];
            end
        end
        snap_d   = snap_q;
        rd_idx_d = rd_idx_q;
        if (rd_en) begin
            if (rd_idx_q == '0) begin
                snap_d = addr_q;
            end
            rd_idx_d = (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= RESET_ADDR;
            stage_q  <= '0;
            snap_q   <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            addr_q   <= addr_d;
            stage_q  <= stage_d;
            snap_q   <= snap_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    assign addr    = addr_q;
    assign ld_busy = (wr_idx_q != '0);
    assign rd_data = rd_en ? rd_byte : '0;

endmodule

// File: rtl/addr_reg_bank.sv
// Bank of NUM_CH byte-loadable address registers on the 8-bit move bus;
// channel i answers to bus code BASE_CODE+i as destination and source.
module addr_reg_bank
    import addr_reg_bank_pkg::*;
#(
    parameter int unsigned        DATA_W     = DATA_WIDTH,
    parameter int unsigned        ADDR_W     = 16,
    parameter int unsigned        NUM_CH     = 2,
    parameter logic [3:0]         BASE_CODE  = AR0,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        addr_bus,
    input  logic [DATA_W-1:0]        data_bus_in,
    output logic [DATA_W-1:0]        data_bus_out,
    input  logic [NUM_CH-1:0]        inc,
    output logic [NUM_CH*ADDR_W-1:0] addr_out,
    output logic [NUM_CH-1:0]        ld_busy
);

    logic [3:0]        dst_code;
    logic [3:0]        src_code;
    logic [DATA_W-1:0] rd_bytes [NUM_CH];

    assign dst_code = addr_bus[3:0];
    assign src_code = addr_bus[7:4];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        addr_reg_chan #(
            .DATA_W     (DATA_W),
            .ADDR_W     (ADDR_W),
            .RESET_ADDR (RESET_ADDR)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (dst_code == chan_code(BASE_CODE, i)),
            .rd_en   (src_code == chan_code(BASE_CODE, i)),
            .wr_data (data_bus_in),
            .inc     (inc[i]),
            .addr    (addr_out[i*ADDR_W +: ADDR_W]),
            .ld_busy (ld_busy[i]),
            .rd_data (rd_bytes[i])
        );
    end

    // Only one channel can be sourced, the others drive zero.
    always_comb begin
        data_bus_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            data_bus_out = data_bus_out | rd_bytes[i];
        end
    end

endmodule

// File: tb/tb_addr_reg_bank.sv
// Scoreboard bench: a 16-bit/2-channel and a 24-bit/4-channel bank share one
// move bus and are checked against a byte-sequence model of the channels.
module tb_addr_reg_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr_bus;
    logic [7:0]  data_bus_in;
    logic [7:0]  dbo0, dbo1;
    logic [1:0]  inc0;
    logic [3:0]  inc1;
    logic [31:0] ao0;
    logic [95:0] ao1;
    logic [1:0]  busy0;
    logic [3:0]  busy1;

    always #5 clk = ~clk;

    addr_reg_bank #(
        .DATA_W(8), .ADDR_W(16), .NUM_CH(2), .BASE_CODE(4'h8), .RESET_ADDR(16'h0)
    ) u_dut16 (
        .clk(clk), .rst(rst), .addr_bus(addr_bus), .data_bus_in(data_bus_in),
        .data_bus_out(dbo0), .inc(inc0), .addr_out(ao0), .ld_busy(busy0)
    );

    addr_reg_bank #(
        .DATA_W(8), .ADDR_W(24), .NUM_CH(4), .BASE_CODE(4'h8), .RESET_ADDR(24'h0)
    ) u_dut24 (
        .clk(clk), .rst(rst), .addr_bus(addr_bus), .data_bus_in(data_bus_in),
        .data_bus_out(dbo1), .inc(inc1), .addr_out(ao1), .ld_busy(busy1)
    );

    typedef struct packed {
        logic [1:0][7:0]       rd;
        logic [1:0][3:0][31:0] addr;
        logic [1:0][3:0]       busy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Model: committed address, bytes received so far, read position and snapshot.
    logic [31:0] m_addr [2][4];
    logic [31:0] m_acc  [2][4];
    logic [31:0] m_snap [2][4];
    int          m_wcnt [2][4];
    int          m_rcnt [2][4];

    function automatic int nb(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int nch(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic logic [31:0] mask(input int d);
        return (d == 0) ? 32'h0000_FFFF : 32'h00FF_FFFF;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                m_addr[d][c] = 0; m_acc[d][c] = 0; m_snap[d][c] = 0;
                m_wcnt[d][c] = 0; m_rcnt[d][c] = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One bus cycle: push expectations for this cycle, then advance the model.
    task automatic cyc(input logic [3:0] dst, input logic [3:0] src, input logic [7:0] din,
                       input logic [3:0] incm, input bit r);
        exp_t        e;
        logic [31:0] v;
        bit          committed [4];
        addr_bus    = {src, dst};
        data_bus_in = din;
        inc0        = incm[1:0];
        inc1        = incm;
        rst         = r;
        e = '0;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < nch(d); c++) begin
                e.addr[d][c] = m_addr[d][c];
                e.busy[d][c] = (m_wcnt[d][c] != 0);
            end
            if (src >= 4'h8 && int'(src) < 8 + nch(d)) begin
                v = (m_rcnt[d][src-8] == 0) ? m_addr[d][src-8] : m_snap[d][src-8];
                e.rd[d] = 8'(v >> (8 * (nb(d) - 1 - m_rcnt[d][src-8])));
            end
        end
        sb.push_back(e);
        if (r) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 4; c++) committed[c] = 1'b0;
                if (src >= 4'h8 && int'(src) < 8 + nch(d)) begin
                    if (m_rcnt[d][src-8] == 0) m_snap[d][src-8] = m_addr[d][src-8];
                    m_rcnt[d][src-8] = (m_rcnt[d][src-8] + 1) % nb(d);
                end
                if (dst >= 4'h8 && int'(dst) < 8 + nch(d)) begin
                    m_acc[d][dst-8]  = ((m_acc[d][dst-8] << 8) | 32'(din)) & mask(d);
                    m_wcnt[d][dst-8] = m_wcnt[d][dst-8] + 1;
                    if (m_wcnt[d][dst-8] == nb(d)) begin
                        m_addr[d][dst-8]  = m_acc[d][dst-8];
                        m_wcnt[d][dst-8]  = 0;
                        committed[dst-8] = 1'b1;
                    end
                end
                for (int c = 0; c < nch(d); c++) begin
                    if (incm[c] && !committed[c]) m_addr[d][c] = (m_addr[d][c] + 1) & mask(d);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are compared mid-cycle, after inputs settle and before the edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rd16", {24'h0, dbo0}, {24'h0, e.rd[0]});
            chk("rd24", {24'h0, dbo1}, {24'h0, e.rd[1]});
            for (int c = 0; c < 2; c++) begin
                chk("addr16", {16'h0, ao0[c*16 +: 16]}, e.addr[0][c]);
                chk("busy16", {31'h0, busy0[c]}, {31'h0, e.busy[0][c]});
            end
            for (int c = 0; c < 4; c++) begin
                chk("addr24", {8'h0, ao1[c*24 +: 24]}, e.addr[1][c]);
                chk("busy24", {31'h0, busy1[c]}, {31'h0, e.busy[1][c]});
            end
        end
    end

    initial begin
        int wait_cnt;
        rst = 1'b1; addr_bus = 8'h00; data_bus_in = 8'h00; inc0 = '0; inc1 = '0;
        model_reset();
        @(posedge clk);
        #1;
        cyc(4'h0, 4'h0, 8'h00, 4'h0, 1'b1);
        cyc(4'h0, 4'h0, 8'h00, 4'h0, 1'b0);
        cyc(4'h0, 4'h0, 8'h00, 4'h0, 1'b0);
        chk("reset_addr16", ao0, 32'h0);
        chk("reset_addr24_lo", ao1[31:0], 32'h0);
        chk("reset_busy", {28'h0, busy1, busy0[1:0] & 2'b11} , 32'h0);
        chk("reset_rd", {16'h0, dbo1, dbo0}, 32'h0);

        // Gapped two-byte load on ch0.
        cyc(4'h8, 4'h0, 8'h12, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("gap_busy", {31'h0, busy0[0]}, 32'h1);
            chk("gap_addr", {16'h0, ao0[15:0]}, 32'h0);
            cyc(4'h0, 4'h0, 8'h00, 4'h0, 1'b0);
        end
        cyc(4'h8, 4'h0, 8'h34, 4'h0, 1'b0);
        chk("commit_1234", {16'h0, ao0[15:0]}, 32'h1234);
        chk("commit_busy", {31'h0, busy0[0]}, 32'h0);

        // Increment wrap and commit-beats-increment on ch1.
        cyc(4'h9, 4'h0, 8'hFF, 4'h0, 1'b0);
        cyc(4'h9, 4'h0, 8'hFF, 4'h0, 1'b0);
        chk("ch1_ffff", {16'h0, ao0[31:16]}, 32'hFFFF);
        cyc(4'h0, 4'h0, 8'h00, 4'h2, 1'b0);
        chk("inc_wrap", {16'h0, ao0[31:16]}, 32'h0);
        cyc(4'h9, 4'h0, 8'hAB, 4'h0, 1'b0);
        cyc(4'h9, 4'h0, 8'hCD, 4'h2, 1'b0);
        chk("commit_wins", {16'h0, ao0[31:16]}, 32'hABCD);

        // Coherent readback across an increment.
        cyc(4'h8, 4'h0, 8'h00, 4'h0, 1'b0);
        cyc(4'h8, 4'h0, 8'hFF, 4'h0, 1'b0);
        addr_bus = 8'h80;
        #1;
        chk("rd_byte0", {24'h0, dbo0}, 32'h00);
        cyc(4'h0, 4'h8, 8'h00, 4'h1, 1'b0);
        chk("rd_byte1_snap", {24'h0, dbo0}, 32'hFF);
        chk("inc_0100", {16'h0, ao0[15:0]}, 32'h0100);
        cyc(4'h0, 4'h8, 8'h00, 4'h0, 1'b0);

        // Reset mid-load on the 24-bit bank, ch3.
        cyc(4'hB, 4'h0, 8'h01, 4'h0, 1'b0);
        cyc(4'hB, 4'h0, 8'h02, 4'h0, 1'b0);
        cyc(4'h0, 4'h0, 8'h00, 4'h0, 1'b1);
        cyc(4'hB, 4'h0, 8'hAA, 4'h0, 1'b0);
        cyc(4'hB, 4'h0, 8'hBB, 4'h0, 1'b0);
        cyc(4'hB, 4'h0, 8'hCC, 4'h0, 1'b0);
        chk("ch3_aabbcc", {8'h0, ao1[95:72]}, 32'hAABBCC);
        chk("ch0_reset", {8'h0, ao1[23:0]}, 32'h0);
        chk("ch2_reset", {8'h0, ao1[71:48]}, 32'h0);

        // Unmapped code.
        cyc(4'h7, 4'h7, 8'h55, 4'h0, 1'b0);
        chk("unmapped_rd", {16'h0, dbo1, dbo0}, 32'h0);
        chk("unmapped_addr16", ao0, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            logic [3:0] d, s, im;
            d  = ($urandom_range(0, 3) == 0) ? 4'(32'($urandom_range(0, 7))) : 4'(32'($urandom_range(8, 15)));
            s  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'(32'($urandom_range(6, 13)));
            im = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            cyc(d, s, 8'($urandom), im, $urandom_range(0, 199) == 0);
        end

        cyc(4'h0, 4'h0, 8'h00, 4'h0, 1'b0);
        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (sb.size() != 0) begin
            chk("scoreboard_drain", 32'(sb.size()), 32'h0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
